// File: rtl/snn_pkg.sv
// Shared spiking-network definitions: LFSR constants, encoder state enum and lane seed/step helpers.
package snn_pkg;

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_t;

    // Lane seed; callers must pick a base so the result is nonzero.
    function automatic logic [LFSR_WIDTH-1:0] seed_for_lane(input logic [LFSR_WIDTH-1:0] base,
                                                            input int unsigned        lane);
        return base ^ LFSR_WIDTH'(lane + 1);
    endfunction

    // Right-shifting Galois step.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// Single-lane 16-bit Galois LFSR; value is the low OUT_W bits used as the random comparand.
module spike_lfsr
    import snn_pkg::*;
#(
    parameter int unsigned            OUT_W      = 8,
    parameter logic [LFSR_WIDTH-1:0]  RESET_SEED = 16'h0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  advance,
    output logic [OUT_W-1:0]      value
);

    logic [LFSR_WIDTH-1:0] state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

    assign value = state[OUT_W-1:0];

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns a frame of pixel intensities into NUM_STEPS Bernoulli spike timesteps.
// Define SPIKE_RATE_ENCODER_RESEED_EN to reload every lane LFSR on each frame acceptance.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int unsigned           NUM_INPUTS  = 4,
    parameter int unsigned           PIXEL_WIDTH = 8,
    parameter int unsigned           NUM_STEPS   = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] in_data,
    input  logic                              step_en,
    output logic [NUM_INPUTS-1:0]             spike_out,
    output logic                              spike_valid,
    output logic                              frame_done,
    output logic                              busy
);

    localparam int unsigned CNT_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0]       LAST_STEP = CNT_W'(NUM_STEPS - 1);
    localparam logic [PIXEL_WIDTH-1:0] PIX_MAX   = '1;

    enc_state_t                 state;
    logic [CNT_W-1:0]           step_cnt;
    logic [PIXEL_WIDTH-1:0]     intensity [NUM_INPUTS];
    logic [PIXEL_WIDTH-1:0]     rnd       [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]      spike_c;
    logic                       accept_c;
    logic                       advance_c;
    logic                       reseed_c;

    assign accept_c  = (state == ENC_IDLE) && in_valid && in_ready;
    assign advance_c = (state == ENC_RUN) && step_en;

`ifdef SPIKE_RATE_ENCODER_RESEED_EN
    assign reseed_c = accept_c;
`else
    assign reseed_c = 1'b0;
`endif

    // Per-lane generator and spike decision; all-ones intensity always fires.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        localparam logic [LFSR_WIDTH-1:0] LANE_SEED = seed_for_lane(LFSR_SEED, 32'(i));

        spike_lfsr #(
            .OUT_W      (PIXEL_WIDTH),
            .RESET_SEED (LANE_SEED)
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .load    (reseed_c),
            .seed    (LANE_SEED),
            .advance (advance_c),
            .value   (rnd[i])
        );

        assign spike_c[i] = (rnd[i] < intensity[i]) || (intensity[i] == PIX_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ENC_IDLE;
            in_ready    <= 1'b0;
            spike_out   <= '0;
            spike_valid <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            step_cnt    <= '0;
            for (int l = 0; l < NUM_INPUTS; l++) begin
                intensity[l] <= '0;
            end
        end else begin
            spike_out   <= '0;
            spike_valid <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                ENC_IDLE: begin
                    if (accept_c) begin
                        for (int l = 0; l < NUM_INPUTS; l++) begin
                            intensity[l] <= in_data[l*PIXEL_WIDTH +: PIXEL_WIDTH];
                        end
                        step_cnt <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ENC_RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ENC_RUN: begin
                    if (step_en) begin
                        spike_out   <= spike_c;
                        spike_valid <= 1'b1;
                        if (step_cnt == LAST_STEP) begin
                            // Release the handshake on the last step so the next frame has no bubble.
                            frame_done <= 1'b1;
                            step_cnt   <= '0;
                            busy       <= 1'b0;
                            in_ready   <= 1'b1;
                            state      <= ENC_IDLE;
                        end else begin
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ENC_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Converts a frame of NUM_INPUTS pixel intensities into Bernoulli/Poisson-like spike trains for NUM_STEPS timesteps.
- Its spike_out vector drives the spike_in port of the IF network, so it is the transmitting end of the spike interface.
- Frames are loaded through a valid/ready handshake. Per-lane LFSRs supply the random comparison values.

Parameters:
- NUM_INPUTS, 4, number of spike lanes; must equal the network's NUM_INPUTS.
- PIXEL_WIDTH, 8, bits per intensity; legal range 1..16.
- NUM_STEPS, 16, timesteps per frame; must be at least 1.
- LFSR_SEED, 16'hACE1, base seed. Lane i seed = LFSR_SEED ^ (i+1); the result must be nonzero.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  frame offer.
- in_ready  output  1  encoder can accept a frame.
- in_data  input  NUM_INPUTS*PIXEL_WIDTH  intensities; lane i occupies bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- step_en  input  1  advance one timestep this cycle.
- spike_out  output  NUM_INPUTS  spikes for the current timestep.
- spike_valid  output  1  spike_out carries a timestep.
- frame_done  output  1  single-cycle pulse coincident with the last timestep of a frame.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; in_ready=0; spike_out=0; spike_valid=0; frame_done=0; busy=0; step counter=0; intensity registers=0; each LFSR = its lane seed.
- After reset release: in_ready goes to 1 at the first clock edge.
- FSM has two states, IDLE and RUN.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid && in_ready: latch in_data, clear the step counter, set in_ready=0 and busy=1, go to RUN.
  - step_en is ignored in IDLE.
- RUN, edge with step_en=1:
  - For each lane, rnd_i = LFSR_i[PIXEL_WIDTH-1:0].
  - spike_out[i] is registered as (rnd_i < intensity_i) || (intensity_i == all-ones).
  - spike_valid is registered 1; all LFSRs advance one step; the counter increments.
- RUN, edge with step_en=0: spike_out=0 and spike_valid=0 are registered; LFSRs and counter hold.
- Final step (counter == NUM_STEPS-1 and step_en=1):
  - Produces the last timestep with frame_done=1.
  - The counter wraps to 0, state returns to IDLE, busy=0 and in_ready=1, all on that same edge.
  - A new frame can therefore be accepted on the next edge, giving back-to-back frames with no bubble beyond the handshake cycle.
- Latency: frame accepted at edge k; the earliest first timestep is visible after edge k+1. Exactly NUM_STEPS valid timesteps are produced per frame.
- Intensity semantics:
  - intensity 0 never spikes.
  - All-ones intensity spikes on every valid timestep.
  - Any other intensity v spikes with probability v/2^PIXEL_WIDTH.
- spike_out is 0 whenever spike_valid is 0; the network may consume spike_out directly.
- in_data and in_valid are ignored while in RUN. in_ready never rises during RUN.
- LFSRs carry state across frames and are reseeded only by reset, unless the optional feature is enabled.
- Reset asserted mid-frame: immediate abort to reset values. No frame_done is issued and the partial frame is discarded.
- LFSR definition: 16-bit Galois, taps mask 16'hB400, shift right. When the LSB is 1, next = (s>>1) ^ 16'hB400; otherwise next = s>>1. The state is never all-zero.

Optional Feature:
- Macro: SPIKE_RATE_ENCODER_RESEED_EN.
- Defined: on every frame acceptance edge, each LFSR is reloaded with its lane seed. The spike train then depends only on the frame data, so identical frames give identical trains, which is useful for matching a golden model.
- Undefined: LFSRs free-run across frames as described in Behaviour.

Decomposition:
- Shared package snn_pkg holds:
  - LFSR_WIDTH=16 and LFSR_TAPS=16'hB400.
  - The encoder state enum (ENC_IDLE, ENC_RUN).
  - A function seed_for_lane(base, i).
- One sub-module, spike_lfsr, implements a single lane generator.
  - Ports: clk, rst, load, seed, advance, value.
  - It is instantiated NUM_INPUTS times in a generate loop.

Test Plan:
- Reset release: in_ready=0 during reset and 1 one edge after release; spike_valid=0; LFSR lane 0 state = 16'hACE1 ^ 1 = 16'hACE0.
- All-zero frame with step_en held 1 for NUM_STEPS=16: 16 cycles with spike_valid=1, spike_out=4'b0000 every cycle, frame_done only on the 16th.
- All-0xFF frame: spike_out=4'b1111 on all 16 valid steps.
- Per-lane intensities 0x40/0x80/0xC0/0x01: per-lane spike counts exactly equal a bit-accurate golden LFSR model.
- step_en toggled 1,0,0,1,...: spike_valid tracks step_en one cycle late, spike_out=0 on stalled cycles, and the frame still totals 16 valid steps.
- Back-to-back frames with in_valid held high: second frame accepted on the edge after frame_done. With SPIKE_RATE_ENCODER_RESEED_EN, identical frames give identical trains.
- rst pulsed at step 7: outputs clear asynchronously, no frame_done is issued, and a fresh frame then produces a full 16 steps.
